// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo-N counter family.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/prescaler.sv
// Enable prescaler: emits a one-cycle tick once every PRESCALE enabled cycles.
module prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clock, reset, clear};
      assign tick          = enable;
    end else begin : g_count
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pc_q, pc_d;

      // enable low freezes the count rather than clearing it
      always_comb begin
        pc_d = pc_q;
        if (clear) begin
          pc_d = '0;
        end else if (enable) begin
          pc_d = (pc_q == LAST) ? '0 : pc_q + PW'(1);
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          pc_q <= '0;
        end else begin
          pc_q <= pc_d;
        end
      end

      assign tick = enable && (pc_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/countermod_n.sv
// Modulo-N up/down counter with prescaler, parallel load, wrap/saturate and cascade flags.
module countermod_n
  import counter_pkg::*;
#(
  parameter int MODULUS     = 4,
  parameter int WIDTH       = $clog2(MODULUS),
  parameter int PRESCALE    = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             terminal,
  output logic             carry,
  output logic             tick
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  count_mode_t      mode_e;

  assign mode_e = count_mode_t'(mode);

  prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .clear (load),
    .tick  (tick)
  );

  // Wrap is detected by comparing against the limits so non-power-of-2
  // moduli never pass through out-of-range codes.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (load) begin
      value_d = ({1'b0, load_value} >= MOD_EXT) ? MAX_V : load_value;
    end else if (tick) begin
      if (up_down == DIR_UP) begin
        if (value_q != MAX_V) begin
          value_d = value_q + WIDTH'(1);
        end else if (mode_e == MODE_WRAP) begin
          value_d = '0;
          carry_d = 1'b1;
        end
      end else begin
        if (value_q != '0) begin
          value_d = value_q - WIDTH'(1);
        end else if (mode_e == MODE_WRAP) begin
          value_d = MAX_V;
          carry_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= RST_V;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value    = value_q;
  assign carry    = carry_q;
  assign terminal = (up_down == DIR_DOWN) ? (value_q == '0) : (value_q == MAX_V);

endmodule

// File: tb/tb_countermod_n.sv
// Randomised bench for countermod_n: three configurations against an integer reference model.
module tb_countermod_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [2:0] en, ud, md, ld;
  logic [1:0] lv0;
  logic [3:0] lv1;
  logic [2:0] lv2;
  logic [1:0] v0;
  logic [3:0] v1;
  logic [2:0] v2;
  logic [2:0] term, car, tck;

  int n_checks = 0;
  int n_errors = 0;
  int mval[3];
  int mpc[3];
  int mcar[3];

  countermod_n #(.MODULUS(4), .PRESCALE(1), .RESET_VALUE(0)) u_dut0 (
    .clock(clock), .reset(reset), .enable(en[0]), .up_down(ud[0]), .mode(md[0]),
    .load(ld[0]), .load_value(lv0), .value(v0), .terminal(term[0]), .carry(car[0]),
    .tick(tck[0]));

  countermod_n #(.MODULUS(10), .PRESCALE(1), .RESET_VALUE(0)) u_dut1 (
    .clock(clock), .reset(reset), .enable(en[1]), .up_down(ud[1]), .mode(md[1]),
    .load(ld[1]), .load_value(lv1), .value(v1), .terminal(term[1]), .carry(car[1]),
    .tick(tck[1]));

  countermod_n #(.MODULUS(6), .PRESCALE(3), .RESET_VALUE(1)) u_dut2 (
    .clock(clock), .reset(reset), .enable(en[2]), .up_down(ud[2]), .mode(md[2]),
    .load(ld[2]), .load_value(lv2), .value(v2), .terminal(term[2]), .carry(car[2]),
    .tick(tck[2]));

  function automatic int mod_of(int i);
    return (i == 0) ? 4 : ((i == 1) ? 10 : 6);
  endfunction

  function automatic int pre_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int rv_of(int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int lv_of(int i);
    return (i == 0) ? int'(lv0) : ((i == 1) ? int'(lv1) : int'(lv2));
  endfunction

  function automatic int dut_val(int i);
    return (i == 0) ? int'(v0) : ((i == 1) ? int'(v1) : int'(v2));
  endfunction

  task automatic check(input string tag, input int idx, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", tag, idx, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mval[i] = rv_of(i);
      mpc[i]  = 0;
      mcar[i] = 0;
    end
  endfunction

  function automatic int model_tick(int i);
    return (en[i] && mpc[i] == pre_of(i) - 1) ? 1 : 0;
  endfunction

  function automatic int model_term(int i);
    return ud[i] ? int'(mval[i] == mod_of(i) - 1) : int'(mval[i] == 0);
  endfunction

  // One rising edge of the counter, from the rules in plain integer arithmetic.
  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      int m;
      int tk;
      int nv;
      m       = mod_of(i);
      tk      = model_tick(i);
      mcar[i] = 0;
      if (ld[i]) begin
        mval[i] = (lv_of(i) < m) ? lv_of(i) : m - 1;
        mpc[i]  = 0;
      end else if (tk != 0) begin
        mpc[i] = 0;
        nv     = ud[i] ? mval[i] + 1 : mval[i] - 1;
        if (nv < 0 || nv >= m) begin
          if (!md[i]) begin
            mval[i] = (nv + m) % m;
            mcar[i] = 1;
          end
        end else begin
          mval[i] = nv;
        end
      end else if (en[i]) begin
        mpc[i] = mpc[i] + 1;
      end
    end
  endfunction

  task automatic cycle();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("tick", i, int'(tck[i]), model_tick(i));
      check("terminal", i, int'(term[i]), model_term(i));
    end
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("value", i, dut_val(i), mval[i]);
      check("carry", i, int'(car[i]), mcar[i]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_value"}, i, dut_val(i), rv_of(i));
      check({tag, "_carry"}, i, int'(car[i]), 0);
    end
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    en = '0; ud = '0; md = '0; ld = '0;
    lv0 = '0; lv1 = '0; lv2 = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    @(negedge clock);
    reset = 1'b1;

    // Up, wrap, free-running
    en = 3'b111; ud = 3'b111; md = 3'b000;
    repeat (6) cycle();
    mid_reset();

    // Down, wrap from reset
    ud = 3'b000;
    repeat (3) cycle();

    // Saturate at the top after a load
    md = 3'b111; ud = 3'b111; ld = 3'b111;
    lv0 = 2'd3; lv1 = 4'd8; lv2 = 3'd4;
    cycle();
    ld = 3'b000;
    repeat (4) cycle();

    // Enable gating of the prescaler
    md = 3'b000;
    foreach (en[k]) en[k] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      en = (k == 2 || k == 5) ? 3'b000 : 3'b111;
      cycle();
    end

    // Load coinciding with a prescaler tick, with clamping
    en = 3'b111;
    for (int k = 0; k < 5 && mpc[2] != 2; k++) cycle();
    check("pc_align", 2, mpc[2], 2);
    ld = 3'b111; lv0 = 2'd1; lv1 = 4'd12; lv2 = 3'd7;
    cycle();
    ld = 3'b000;
    repeat (4) cycle();

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      en  = 3'($urandom) | 3'($urandom);
      ud  = 3'($urandom);
      md  = 3'($urandom);
      ld  = 3'($urandom) & 3'($urandom) & 3'($urandom);
      lv0 = 2'($urandom);
      lv1 = 4'($urandom);
      lv2 = 3'($urandom);
      cycle();
      if ($urandom_range(0, 49) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
